cache_nway_ctrl: RTL
====================

Name: cache_nway_ctrl

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache with an integrated controller and datapath.
- Successor to the fixed 2-way cache datapath/mux arrangement: generalised way count and set count, tree pseudo-LRU replacement, internal tag/valid/dirty/data storage and miss FSM.
- Sits between the pipeline's 256-bit line adaptor (CPU side) and physical memory / arbiter (pmem side).

Parameters:
WAYS, 4, associativity; power of 2, legal range 2..8 (elaboration error otherwise)
SET_BITS, 3, index width; sets = 2**SET_BITS, legal range 1..6
TAG_BITS, 27-SET_BITS, derived (localparam), address bits [31:5+SET_BITS]

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
mem_address  in  32  CPU byte address; [4:0] ignored, index [5+SET_BITS-1:5]
mem_read  in  1  read request, held until mem_resp
mem_write  in  1  write request, held until mem_resp
mem_byte_enable256  in  32  per-byte write enable
mem_wdata256  in  256  write data
mem_rdata256  out  256  read data, valid while mem_resp=1
mem_resp  out  1  one-cycle completion pulse
pmem_address  out  32  line address, [4:0]=0
pmem_read  out  1  line fill request
pmem_write  out  1  line writeback request
pmem_wdata  out  256  writeback data
pmem_rdata  in  256  fill data, valid with pmem_resp
pmem_resp  in  1  memory completion pulse

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all valid, dirty, PLRU bits=0; every output=0 immediately. Tag and data arrays not reset. Reset mid-WB/FILL abandons the transaction; dirty contents are lost.
- States: IDLE, RESP, WB, FILL.
- IDLE: lookup (combinational) when mem_read|mem_write. Hit = valid & tag match in any way; at most one way matches.
  - Hit read: register line into mem_rdata256, update PLRU, -> RESP.
  - Hit write: merge mem_wdata256 per byte enable (byte i = bits [8i+7:8i]), set dirty, update PLRU, -> RESP.
  - Miss: victim = lowest-index invalid way, else PLRU victim; latch victim way. Victim valid & dirty -> WB, else -> FILL.
  - mem_read and mem_write both high: treated as write.
- RESP: mem_resp=1 for exactly one cycle -> IDLE. Hit latency: request in cycle 0, mem_resp in cycle 1.
- WB: pmem_write=1, pmem_address={victim tag, index, 5'b0}, pmem_wdata=victim line, all held stable. On pmem_resp: clear victim dirty -> FILL.
- FILL: pmem_read=1, pmem_address={mem_address[31:5], 5'b0}. On pmem_resp: write pmem_rdata into victim way, tag=request tag, valid=1, dirty=0 -> IDLE. The re-lookup hits and completes via the normal hit path; a write completes its merge there.
- pmem_resp outside WB/FILL is ignored. mem_resp is never asserted outside RESP.
- PLRU: per set, WAYS-1 tree bits, heap order (node 1 = root). Node bit 0 = victim in left (lower-index) half, 1 = right half.
  - Access to way w sets every node on its path to point away from w.
  - Victim = walk from the root following the bits.
  - WAYS=2 degenerates to one bit: 1 means way 1 is victim.
- Address split: index=mem_address[5+SET_BITS-1:5], tag=mem_address[31:5+SET_BITS].

Test Plan:
1. Reset, read 0x0000_0040 miss -> pmem_read with pmem_address=0x0000_0040; pmem_resp after 3 cycles, pmem_rdata=D -> mem_resp pulse, mem_rdata256=D. Repeat read -> mem_resp 1 cycle after request, no pmem activity.
2. Write hit to 0x0000_0040, byte_enable=0x0000_000F, wdata=all 0xFF -> later read returns D with bytes 0-3=0xFF, rest unchanged. No pmem traffic until eviction.
3. WAYS=4, SET_BITS=3: read 0x000, 0x100, 0x200, 0x300, then 0x000 (all set 0); read 0x400 -> miss evicts way holding 0x200 (clean, no pmem_write). Read 0x200 again -> miss.
4. Dirty writeback: write 0x000 (be=0xFFFF_FFFF, data W), then read 0x100..0x400 in set 0 -> pmem_write with pmem_address=0x000, pmem_wdata=W precedes pmem_read of the new line.
5. Write miss to 0x0000_0800 -> FILL, then merge; mem_resp once. Subsequent read returns fill data with enabled bytes replaced.
6. rst_n low during FILL (pmem_read=1) -> pmem_read, mem_resp and all outputs 0 asynchronously. After release, read of a previously cached address misses.

Source files
------------

// File: rtl/cache_nway_ctrl.sv
// N-way set-associative, write-back / write-allocate cache with tree pseudo-LRU replacement.
// Per-way tag comparators feed a four-state miss controller (IDLE / RESP / WB / FILL).

module cache_way_cmp #(
  parameter int TAG_BITS = 24
) (
  input  logic                valid,
  input  logic [TAG_BITS-1:0] tag_stored,
  input  logic [TAG_BITS-1:0] tag_req,
  output logic                hit
);
  assign hit = valid & (tag_stored == tag_req);
endmodule

module cache_nway_ctrl #(
  parameter int WAYS     = 4,
  parameter int SET_BITS = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_byte_enable256,
  input  logic [255:0] mem_wdata256,
  output logic [255:0] mem_rdata256,
  output logic         mem_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);
  localparam int TAG_BITS = 27 - SET_BITS;
  localparam int SETS     = 1 << SET_BITS;
  localparam int LVL      = $clog2(WAYS);

  if (WAYS < 2 || WAYS > 8 || (WAYS & (WAYS - 1)) != 0) begin : g_bad_ways
    $error("cache_nway_ctrl: WAYS must be 2, 4 or 8");
  end
  if (SET_BITS < 1 || SET_BITS > 6) begin : g_bad_sets
    $error("cache_nway_ctrl: SET_BITS must be in 1..6");
  end

  typedef enum logic [1:0] {IDLE, RESP, WB, FILL} state_t;
  state_t state, state_nxt;

  logic [TAG_BITS-1:0] tag_arr  [WAYS][SETS];
  logic [255:0]        data_arr [WAYS][SETS];
  logic [WAYS-1:0]     valid_arr [SETS];
  logic [WAYS-1:0]     dirty_arr [SETS];
  // Heap-ordered tree bits: bit n is node n (root = 1), bit 0 is never used.
  logic [WAYS-1:0]     plru_arr  [SETS];

  logic [SET_BITS-1:0] idx;
  logic [TAG_BITS-1:0] tag_req;
  logic                req;
  logic                unused_low;

  assign idx        = mem_address[5 +: SET_BITS];
  assign tag_req    = mem_address[31 -: TAG_BITS];
  assign req        = mem_read | mem_write;
  assign unused_low = ^mem_address[4:0];

  logic [WAYS-1:0] way_hit;
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_way_cmp #(.TAG_BITS(TAG_BITS)) u_cmp (
      .valid      (valid_arr[idx][w]),
      .tag_stored (tag_arr[w][idx]),
      .tag_req    (tag_req),
      .hit        (way_hit[w])
    );
  end

  logic           hit;
  logic [LVL-1:0] hit_way;
  logic [255:0]   hit_line, merged;
  logic [WAYS-1:0] plru_cur;

  assign plru_cur = plru_arr[idx];
  assign hit_line = data_arr[hit_way][idx];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (way_hit[w]) begin
        hit     = 1'b1;
        hit_way = LVL'(w);
      end
    for (int i = 0; i < 32; i++)
      merged[8*i +: 8] = mem_byte_enable256[i] ? mem_wdata256[8*i +: 8] : hit_line[8*i +: 8];
  end

  logic           inv_found;
  logic [LVL-1:0] inv_way, plru_way, miss_way, victim_q;

  // Prefer the lowest invalid way, otherwise follow the tree from the root.
  always_comb begin
    logic [LVL-1:0] node;
    inv_found = 1'b0;
    inv_way   = '0;
    plru_way  = '0;
    for (int w = WAYS-1; w >= 0; w--)
      if (!valid_arr[idx][w]) begin
        inv_found = 1'b1;
        inv_way   = LVL'(w);
      end
    node = LVL'(1);
    for (int l = 0; l < LVL; l++) begin
      plru_way[LVL-1-l] = plru_cur[node];
      node = LVL'({node, plru_cur[node]});
    end
    miss_way = inv_found ? inv_way : plru_way;
  end

  // Point every node on the accessed way's path at the other half.
  function automatic logic [WAYS-1:0] plru_touch(input logic [WAYS-1:0] cur,
                                                 input logic [LVL-1:0]  way);
    logic [WAYS-1:0] nxt;
    logic [LVL-1:0]  node;
    nxt  = cur;
    node = LVL'(1);
    for (int l = 0; l < LVL; l++) begin
      nxt[node] = ~way[LVL-1-l];
      node      = LVL'({node, way[LVL-1-l]});
    end
    return nxt;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    unique case (state)
      IDLE: if (req) begin
        if (hit)                                             state_nxt = RESP;
        else if (valid_arr[idx][miss_way] && dirty_arr[idx][miss_way]) state_nxt = WB;
        else                                                 state_nxt = FILL;
      end
      RESP: begin
        mem_resp  = 1'b1;
        state_nxt = IDLE;
      end
      WB: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_arr[victim_q][idx], idx, 5'b0};
        pmem_wdata   = data_arr[victim_q][idx];
        if (pmem_resp) state_nxt = FILL;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {mem_address[31:5], 5'b0};
        if (pmem_resp) state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_arr[s] <= '0;
        dirty_arr[s] <= '0;
        plru_arr[s]  <= '0;
      end
      victim_q     <= '0;
      mem_rdata256 <= '0;
    end else begin
      unique case (state)
        IDLE: if (req) begin
          if (hit) begin
            plru_arr[idx] <= plru_touch(plru_cur, hit_way);
            if (mem_write) dirty_arr[idx][hit_way] <= 1'b1;
            else           mem_rdata256 <= hit_line;
          end else begin
            victim_q <= miss_way;
          end
        end
        WB:   if (pmem_resp) dirty_arr[idx][victim_q] <= 1'b0;
        FILL: if (pmem_resp) begin
          valid_arr[idx][victim_q] <= 1'b1;
          dirty_arr[idx][victim_q] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Tag and data storage carry no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (state == IDLE && req && hit && mem_write)
      data_arr[hit_way][idx] <= merged;
    if (state == FILL && pmem_resp) begin
      data_arr[victim_q][idx] <= pmem_rdata;
      tag_arr[victim_q][idx]  <= tag_req;
    end
  end

endmodule
